// File: rtl/bcd_cvt_arbiter_pkg.sv
// Shared types and helpers for the BCD converter arbiter: FSM state encoding,
// timeout fill value and the index-width helper.
package bcd_cvt_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Every result bit is forced to this value when the converter times out.
  localparam logic TIMEOUT_FILL = 1'b1;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w = w + 1;
    return w;
  endfunction

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/bcd_cvt_arbiter_rr_arbiter.sv
// Combinational rotate-priority pick: searches req starting at ptr+1 (mod N_REQ)
// and returns the first hit as one-hot plus binary index.
module rr_arbiter
  import bcd_cvt_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [IDX_W-1:0] slot;

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    slot   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      slot = IDX_W'((int'(ptr) + i) % N_REQ);
      if (!valid && req[slot]) begin
        onehot[slot] = 1'b1;
        idx          = slot;
        valid        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_cvt_arbiter.sv
// Round-robin sharing of one BCD converter among N_REQ sources, one job in flight.
// Optional WAIT watchdog enabled by defining BCD_ARB_TIMEOUT_EN.
module bcd_cvt_arbiter
  import bcd_cvt_arbiter_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int DATA_IN_WIDTH  = 20,
  parameter int DATA_OUT_WIDTH = 24,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_REQ-1:0]                 req_i,
  input  logic [N_REQ*DATA_IN_WIDTH-1:0]   req_data_i,
  output logic [N_REQ-1:0]                 gnt_o,
  output logic [N_REQ-1:0]                 rsp_valid_o,
  output logic [DATA_OUT_WIDTH-1:0]        rsp_data_o,
  output logic                             err_o,
  output logic                             busy_o,
  output logic                             cvt_en_o,
  output logic [DATA_IN_WIDTH-1:0]         cvt_data_o,
  input  logic [DATA_OUT_WIDTH-1:0]        cvt_data_i,
  input  logic                             cvt_busy_i,
  input  logic                             cvt_rdy_i
);

  localparam int               IDX_W = idx_width(N_REQ);
  localparam logic [N_REQ-1:0] ONE   = N_REQ'(1);

  if (N_REQ < 2) begin : g_n_req_check
    $error("bcd_cvt_arbiter needs at least two requesters");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
    $error("bcd_cvt_arbiter TIMEOUT_CYCLES must be positive");
  end

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] idx;
  logic [N_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req    (req_i),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

`ifdef BCD_ARB_TIMEOUT_EN
  localparam int TO_W = idx_width(TIMEOUT_CYCLES);
  logic [TO_W-1:0] to_cnt;
`endif

  // cvt_data_o doubles as the operand latch: it is loaded at the grant decision
  // and held until the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ptr         <= IDX_W'(N_REQ - 1);
      idx         <= '0;
      gnt_o       <= '0;
      rsp_valid_o <= '0;
      rsp_data_o  <= '0;
      err_o       <= 1'b0;
      busy_o      <= 1'b0;
      cvt_en_o    <= 1'b0;
      cvt_data_o  <= '0;
`ifdef BCD_ARB_TIMEOUT_EN
      to_cnt      <= '0;
`endif
    end else begin
      gnt_o       <= '0;
      cvt_en_o    <= 1'b0;
      rsp_valid_o <= '0;
      err_o       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid && !cvt_busy_i) begin
            idx        <= pick_idx;
            gnt_o      <= pick_onehot;
            cvt_en_o   <= 1'b1;
            cvt_data_o <= req_data_i[pick_idx*DATA_IN_WIDTH +: DATA_IN_WIDTH];
            busy_o     <= 1'b1;
            state      <= ST_START;
          end
        end
        ST_START: begin
          ptr   <= idx;
          state <= ST_WAIT;
`ifdef BCD_ARB_TIMEOUT_EN
          to_cnt <= TO_W'(TIMEOUT_CYCLES - 1);
`endif
        end
        ST_WAIT: begin
          if (cvt_rdy_i) begin
            rsp_data_o  <= cvt_data_i;
            rsp_valid_o <= ONE << idx;
            state       <= ST_DONE;
          end
`ifdef BCD_ARB_TIMEOUT_EN
          else if (to_cnt == '0) begin
            rsp_data_o  <= {DATA_OUT_WIDTH{TIMEOUT_FILL}};
            rsp_valid_o <= ONE << idx;
            err_o       <= 1'b1;
            state       <= ST_DONE;
          end else begin
            to_cnt <= to_cnt - 1'b1;
          end
`endif
        end
        ST_DONE: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_cvt_arbiter.sv
// Self-checking bench for bcd_cvt_arbiter with a 22-cycle converter model,
// a vector table, directed corner sequences and a randomized scoreboard phase.
module tb_bcd_cvt_arbiter;

  localparam int N   = 2;
  localparam int WI  = 20;
  localparam int WO  = 24;
  localparam int LAT = 22;
  localparam int TO  = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_i = '0;
  logic [N*WI-1:0] req_data_i;
  logic [N-1:0]    gnt_o, rsp_valid_o;
  logic [WO-1:0]   rsp_data_o;
  logic            err_o, busy_o, cvt_en_o;
  logic [WI-1:0]   cvt_data_o;
  logic [WO-1:0]   cvt_data_i = '0;
  logic            cvt_busy_i;
  logic            cvt_rdy_i = 1'b0;

  logic [WI-1:0]   data [N];
  logic [N-1:0]    drop_mask = '1;
  bit              mon_en = 1'b1;
  bit              model_mute = 1'b0;
  bit              busy_force = 1'b0;
  int              n_chk = 0;
  int              n_pass = 0;

  initial begin
    data[0] = '0;
    data[1] = '0;
  end
  assign req_data_i = {data[1], data[0]};

  always #5 clk = ~clk;

  bcd_cvt_arbiter #(
    .N_REQ          (N),
    .DATA_IN_WIDTH  (WI),
    .DATA_OUT_WIDTH (WO),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .req_data_i  (req_data_i),
    .gnt_o       (gnt_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_data_o  (rsp_data_o),
    .err_o       (err_o),
    .busy_o      (busy_o),
    .cvt_en_o    (cvt_en_o),
    .cvt_data_o  (cvt_data_o),
    .cvt_data_i  (cvt_data_i),
    .cvt_busy_i  (cvt_busy_i),
    .cvt_rdy_i   (cvt_rdy_i)
  );

  function automatic logic [WO-1:0] to_bcd(input int v);
    logic [WO-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int d = 0; d < WO / 4; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic timeout_fail(input string name);
    n_chk++;
    $display("FAIL %s: no event within bound, required one", name);
  endtask

  // Converter model: fixed latency, busy while counting, 1-cycle rdy strobe.
  int            mdl_cnt = 0;
  logic [WI-1:0] mdl_op = '0;
  always @(posedge clk) begin
    cvt_rdy_i <= 1'b0;
    if (mdl_cnt > 0) begin
      mdl_cnt <= mdl_cnt - 1;
      if (mdl_cnt == 1) begin
        cvt_rdy_i  <= 1'b1;
        cvt_data_i <= to_bcd(int'(mdl_op));
      end
    end else if (cvt_en_o === 1'b1 && !model_mute) begin
      mdl_cnt <= LAT;
      mdl_op  <= cvt_data_o;
    end
  end
  assign cvt_busy_i = (mdl_cnt != 0) || busy_force;

  // Reference model: rotating priority after the last grant, FIFO of expected results.
  logic [N-1:0]  prev_req = '0;
  logic [WI-1:0] prev_data [N];
  int            last_gnt = N - 1;
  int            mon_w;
  int            exp_idx_q[$];
  logic [WO-1:0] exp_bcd_q[$];
  int            e_idx;
  logic [WO-1:0] e_bcd;
  int            jobs = 0;

  always @(negedge clk) begin
    if (rst) begin
      last_gnt = N - 1;
      exp_idx_q.delete();
      exp_bcd_q.delete();
    end else begin
      if (gnt_o != '0) begin
        mon_w = -1;
        for (int s = 1; s <= N; s++)
          if (mon_w < 0 && prev_req[(last_gnt + s) % N]) mon_w = (last_gnt + s) % N;
        if (mon_en) begin
          if (mon_w < 0) chk("mon_gnt_without_req", 32'(gnt_o), 32'd0);
          else begin
            chk("mon_gnt", 32'(gnt_o), 32'(1 << mon_w));
            chk("mon_cvt_en", 32'(cvt_en_o), 32'd1);
            chk("mon_cvt_data", 32'(cvt_data_o), 32'(prev_data[mon_w]));
          end
        end
        if (mon_w >= 0) begin
          last_gnt = mon_w;
          exp_idx_q.push_back(mon_w);
          exp_bcd_q.push_back(to_bcd(int'(prev_data[mon_w])));
          jobs++;
        end
      end
      if (rsp_valid_o != '0) begin
        if (exp_idx_q.size() == 0) begin
          if (mon_en) chk("mon_rsp_unexpected", 32'(rsp_valid_o), 32'd0);
        end else begin
          e_idx = exp_idx_q.pop_front();
          e_bcd = exp_bcd_q.pop_front();
          if (mon_en) begin
            chk("mon_rsp_valid", 32'(rsp_valid_o), 32'(1 << e_idx));
            chk("mon_rsp_data", 32'(rsp_data_o), 32'(e_bcd));
            chk("mon_rsp_err", 32'(err_o), 32'd0);
          end
        end
      end
    end
    prev_req  = req_i;
    prev_data = data;
  end

  task automatic step();
    @(posedge clk);
    #1;
    req_i = req_i & ~(gnt_o & drop_mask);
  endtask

  task automatic do_reset();
    req_i = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_gnt(input int max, output bit ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    while (cyc <= max) begin
      if (gnt_o != '0) begin
        ok = 1'b1;
        break;
      end
      step();
      cyc++;
    end
    if (!ok) timeout_fail("wait_gnt");
  endtask

  task automatic wait_rsp(input int max, output bit ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    while (cyc <= max) begin
      if (rsp_valid_o != '0) begin
        ok = 1'b1;
        break;
      end
      step();
      cyc++;
    end
    if (!ok) timeout_fail("wait_rsp");
  endtask

  typedef struct {
    logic [N-1:0]  req;
    logic [WI-1:0] d0;
    logic [WI-1:0] d1;
    logic [N-1:0]  gnt;
    logic [WI-1:0] op;
    logic [WO-1:0] bcd;
  } vec_t;

  vec_t vecs[5];

  initial begin
    bit ok;
    int cyc, n;
    logic [N-1:0] ord [4];

    vecs[0] = '{2'b01, 20'd12345,  20'd0,      2'b01, 20'd12345,  24'h012345};
    vecs[1] = '{2'b10, 20'd0,      20'd999999, 2'b10, 20'd999999, 24'h999999};
    vecs[2] = '{2'b11, 20'd500,    20'd7,      2'b01, 20'd500,    24'h000500};
    vecs[3] = '{2'b10, 20'd0,      20'd1,      2'b10, 20'd1,      24'h000001};
    vecs[4] = '{2'b01, 20'd0,      20'd3,      2'b01, 20'd0,      24'h000000};
    ord[0] = 2'b01; ord[1] = 2'b10; ord[2] = 2'b01; ord[3] = 2'b10;

    do_reset();
    chk("reset_gnt", 32'(gnt_o), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data_o), 32'd0);
    chk("reset_err", 32'(err_o), 32'd0);
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_cvt_en", 32'(cvt_en_o), 32'd0);
    chk("reset_cvt_data", 32'(cvt_data_o), 32'd0);

    // Vector table: one job each from reset.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      drop_mask = '1;
      data[0] = vecs[i].d0;
      data[1] = vecs[i].d1;
      req_i   = vecs[i].req;
      wait_gnt(10, ok, cyc);
      if (ok) begin
        chk("vec_gnt_latency", 32'(cyc), 32'd1);
        chk("vec_gnt", 32'(gnt_o), 32'(vecs[i].gnt));
        chk("vec_cvt_en", 32'(cvt_en_o), 32'd1);
        chk("vec_cvt_data", 32'(cvt_data_o), 32'(vecs[i].op));
        cyc = 0;
        while (cvt_rdy_i !== 1'b1 && cyc < 60) begin
          step();
          cyc++;
        end
        if (cvt_rdy_i !== 1'b1) timeout_fail("vec_wait_rdy");
        else begin
          step();
          chk("vec_rsp_valid", 32'(rsp_valid_o), 32'(vecs[i].gnt));
          chk("vec_rsp_data", 32'(rsp_data_o), 32'(vecs[i].bcd));
          chk("vec_err", 32'(err_o), 32'd0);
        end
      end
      req_i = '0;
      repeat (4) step();
    end

    // Both held: alternate grants, exactly one idle cycle between jobs.
    do_reset();
    drop_mask = '0;
    data[0] = 20'd11;
    data[1] = 20'd22;
    req_i = 2'b11;
    for (int j = 0; j < 4; j++) begin
      wait_gnt(60, ok, cyc);
      chk("t2_order", 32'(gnt_o), 32'(ord[j]));
      if (j < 3) begin
        wait_rsp(60, ok, cyc);
        n = 0;
        step();
        while (!busy_o && n < 10) begin
          n++;
          step();
        end
        chk("t2_idle_gap", 32'(n), 32'd1);
      end
    end
    req_i = '0;
    drop_mask = '1;
    wait_rsp(60, ok, cyc);

    // req0 raised while req1's job is in WAIT is served next.
    do_reset();
    drop_mask = 2'b01;
    data[1] = 20'd777;
    req_i = 2'b10;
    wait_gnt(10, ok, cyc);
    chk("t3_first", 32'(gnt_o), 32'b10);
    repeat (5) step();
    data[0] = 20'd4242;
    req_i[0] = 1'b1;
    wait_rsp(60, ok, cyc);
    wait_gnt(10, ok, cyc);
    chk("t3_req0_next", 32'(gnt_o), 32'b01);
    wait_rsp(60, ok, cyc);
    wait_gnt(10, ok, cyc);
    chk("t3_req1_after", 32'(gnt_o), 32'b10);
    req_i = '0;
    drop_mask = '1;
    wait_rsp(60, ok, cyc);

    // Converter busy blocks the grant; grant follows one cycle after busy falls.
    do_reset();
    busy_force = 1'b1;
    data[0] = 20'd321;
    req_i = 2'b01;
    n = 0;
    repeat (6) begin
      step();
      if (gnt_o != '0) n++;
    end
    chk("t4_no_gnt_while_busy", 32'(n), 32'd0);
    busy_force = 1'b0;
    step();
    chk("t4_gnt_after_busy", 32'(gnt_o), 32'b01);
    wait_rsp(60, ok, cyc);

    // Reset during WAIT aborts the job; late rdy produces no response.
    do_reset();
    data[0] = 20'd4321;
    req_i = 2'b01;
    wait_gnt(10, ok, cyc);
    repeat (6) step();
    chk("t5_busy_in_wait", 32'(busy_o), 32'd1);
    rst = 1'b1;
    step();
    chk("t5_gnt", 32'(gnt_o), 32'd0);
    chk("t5_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("t5_rsp_data", 32'(rsp_data_o), 32'd0);
    chk("t5_err", 32'(err_o), 32'd0);
    chk("t5_busy", 32'(busy_o), 32'd0);
    chk("t5_cvt_en", 32'(cvt_en_o), 32'd0);
    chk("t5_cvt_data", 32'(cvt_data_o), 32'd0);
    rst = 1'b0;
    n = 0;
    repeat (40) begin
      step();
      if (rsp_valid_o != '0) n++;
    end
    chk("t5_no_rsp", 32'(n), 32'd0);
    data[0] = 20'd5;
    data[1] = 20'd6;
    req_i = 2'b11;
    wait_gnt(10, ok, cyc);
    chk("t5_req0_first", 32'(gnt_o), 32'b01);
    wait_rsp(60, ok, cyc);
    wait_gnt(10, ok, cyc);
    chk("t5_req1_second", 32'(gnt_o), 32'b10);
    wait_rsp(60, ok, cyc);

    // Converter never answers.
    do_reset();
    mon_en = 1'b0;
    model_mute = 1'b1;
    data[0] = 20'd9;
    req_i = 2'b01;
    wait_gnt(10, ok, cyc);
`ifdef BCD_ARB_TIMEOUT_EN
    wait_rsp(TO + 20, ok, cyc);
    if (ok) begin
      chk("t6_rsp_valid", 32'(rsp_valid_o), 32'b01);
      chk("t6_rsp_data", 32'(rsp_data_o), 32'hFFFFFF);
      chk("t6_err", 32'(err_o), 32'd1);
      chk("t6_latency_window", 32'(cyc >= TO && cyc <= TO + 4), 32'd1);
    end
`else
    n = 0;
    cyc = 0;
    repeat (100) begin
      step();
      if (rsp_valid_o != '0) n++;
      if (!busy_o) cyc++;
    end
    chk("t6_no_rsp", 32'(n), 32'd0);
    chk("t6_busy_held", 32'(cyc), 32'd0);
    chk("t6_err_low", 32'(err_o), 32'd0);
`endif
    model_mute = 1'b0;
    do_reset();
    mon_en = 1'b1;

    // Randomized traffic against the scoreboard.
    jobs = 0;
    drop_mask = '1;
    for (int c = 0; c < 3000; c++) begin
      step();
      busy_force = ($urandom_range(0, 9) == 0);
      for (int k = 0; k < N; k++) begin
        if (!req_i[k] && $urandom_range(0, 3) == 0) begin
          data[k] = WI'($urandom_range(0, 999999));
          req_i[k] = 1'b1;
        end
      end
    end
    busy_force = 1'b0;
    req_i = '0;
    repeat (100) step();
    chk("rand_drained", 32'(exp_idx_q.size()), 32'd0);
    chk("rand_activity", 32'(jobs >= 50), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_watchdog: simulation still running, required completion");
    $fatal(1);
  end

endmodule
